// File: rtl/trace_pkg.sv
// Trace entry layout shared by commit_trace_fifo and its bench.
// COMMIT_TRACE_TIMESTAMP_EN adds a cycle timestamp in the entry MSBs.
package trace_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned TS_W   = 32;

    typedef struct packed {
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        logic [TS_W-1:0]   ts;
`endif
        logic              reg_v;
        logic [REG_W-1:0]  reg_num;
        logic [DATA_W-1:0] reg_data;
        logic              mem_we;
        logic              mem_re;
        logic [ADDR_W-1:0] mem_addr;
        logic [DATA_W-1:0] mem_data;
    } trace_entry_t;

    localparam int unsigned BASE_W = 1 + REG_W + DATA_W + 1 + 1 + ADDR_W + DATA_W;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
    localparam int unsigned ENTRY_W = BASE_W + TS_W;
`else
    localparam int unsigned ENTRY_W = BASE_W;
`endif

    // Bit offsets of each field inside the flat entry, LSB first.
    localparam int unsigned MEM_DATA_LSB = 0;
    localparam int unsigned MEM_ADDR_LSB = MEM_DATA_LSB + DATA_W;
    localparam int unsigned MEM_RE_BIT   = MEM_ADDR_LSB + ADDR_W;
    localparam int unsigned MEM_WE_BIT   = MEM_RE_BIT + 1;
    localparam int unsigned REG_DATA_LSB = MEM_WE_BIT + 1;
    localparam int unsigned REG_NUM_LSB  = REG_DATA_LSB + DATA_W;
    localparam int unsigned REG_V_BIT    = REG_NUM_LSB + REG_W;
    localparam int unsigned TS_LSB       = BASE_W;

endpackage

// File: rtl/trace_fifo_ram.sv
// Entry storage: synchronous write, combinational read by address.
module trace_fifo_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 81,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_fifo.sv
// Packs per-cycle core commit events into trace entries and drains them over valid/ready.
// Optional COMMIT_TRACE_TIMESTAMP_EN stamps each entry with a free-running cycle count.
module commit_trace_fifo
    import trace_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DATA_W,
    parameter int unsigned ADDR_WIDTH     = ADDR_W,
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned DROP_CNT_WIDTH = 16,
    parameter int unsigned TS_WIDTH       = TS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      RegWriteSignal,
    input  logic [4:0]                RegNum,
    input  logic [DATA_WIDTH-1:0]     RegData,
    input  logic                      WriteEnable,
    input  logic                      ReadEnable,
    input  logic [ADDR_WIDTH-1:0]     Address,
    input  logic [DATA_WIDTH-1:0]     WriteData,
    input  logic [DATA_WIDTH-1:0]     ReadData,
    output logic                      TraceValid,
    input  logic                      TraceReady,
    output logic [ENTRY_W-1:0]        TraceEntry,
    output logic                      Overflow,
    output logic [DROP_CNT_WIDTH-1:0] DropCount,
    output logic [$clog2(DEPTH):0]    Level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // The entry struct is sized by the package; overrides must agree with it.
    if (DATA_WIDTH != DATA_W || ADDR_WIDTH != ADDR_W || TS_WIDTH != TS_W ||
        DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_param_check
        $error("commit_trace_fifo: unsupported parameter combination");
    end

    logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic          reg_ev, mem_ev, push, pop, full, empty, push_acc, drop;
    trace_entry_t  new_entry, head_nxt;
    logic [ENTRY_W-1:0] ram_rdata;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_WIDTH'(1);
        end
    end
`endif

    assign reg_ev = RegWriteSignal & (RegNum != 5'd0);
    assign mem_ev = WriteEnable | ReadEnable;
    assign push   = reg_ev | mem_ev;

    // Build this cycle's entry; unqualified field groups stay zero.
    always_comb begin
        new_entry = '0;
        if (reg_ev) begin
            new_entry.reg_v    = 1'b1;
            new_entry.reg_num  = RegNum;
            new_entry.reg_data = RegData;
        end
        if (mem_ev) begin
            new_entry.mem_we   = WriteEnable;
            new_entry.mem_re   = ReadEnable;
            new_entry.mem_addr = Address;
            new_entry.mem_data = WriteEnable ? WriteData : ReadData;
        end
`ifdef COMMIT_TRACE_TIMESTAMP_EN
        new_entry.ts = TS_W'(ts_cnt);
`endif
    end

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop      = ~empty & TraceReady;
    assign push_acc = push & (~full | pop);
    assign drop     = push & full & ~pop;
    assign wr_nxt   = wr_ptr + PW'(push_acc);
    assign rd_nxt   = rd_ptr + PW'(pop);

    trace_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (new_entry),
        .raddr (rd_nxt[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Next head: the RAM still holds the old slot this cycle, so an entry pushed into an empty FIFO is forwarded.
    always_comb begin
        head_nxt = ram_rdata;
        if (wr_nxt == rd_nxt) begin
            head_nxt = '0;
        end else if (push_acc && (rd_nxt == wr_ptr)) begin
            head_nxt = new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            TraceValid <= 1'b0;
            TraceEntry <= '0;
            Level      <= '0;
            Overflow   <= 1'b0;
            DropCount  <= '0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            TraceValid <= (wr_nxt != rd_nxt);
            TraceEntry <= head_nxt;
            Level      <= wr_nxt - rd_nxt;
            if (drop) begin
                Overflow <= 1'b1;
                if (DropCount != '1) begin
                    DropCount <= DropCount + DROP_CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
